// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder, DIGIT bits per clock, LSB digit first.
// Operands sit in shift registers and a registered carry links the digits.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' port for a - b - c_in.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;

  // Operand B / carry-in as loaded: inverted for subtraction (two's complement via ~b + ~c_in)
  always_comb begin
    b_ld   = b;
    cin_ld = c_in;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_ld   = ~b;
      cin_ld = ~c_in;
    end
`endif
  end

  // One digit of the addition: {carry, digit sum}
  always_comb begin
    dsum = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  end

  // New digit enters at the top of the accumulator; after NDIG shifts it is aligned
  if (DIGIT == WIDTH) begin : g_acc_full
    assign acc_nxt = dsum[DIGIT-1:0];
  end else begin : g_acc_shift
    assign acc_nxt = {dsum[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath: load on accepted start, one digit per RUN cycle. The result
  // registers are written on the last RUN edge so they are already valid
  // during the DONE cycle alongside the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opa   <= a;
          opb   <= b_ld;
          carry <= cin_ld;
          cnt   <= CW'(NDIG - 1);
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= dsum[DIGIT];
          acc   <= acc_nxt;
          if (cnt == '0) begin
            sum   <= acc_nxt;
            c_out <= dsum[DIGIT];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
